// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command framer.
package serial_cmd_pkg;

  // Frame parser states; HOLD keeps a checked command for the consumer.
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

  // Position of each field in a frame, in arrival order.
  localparam int unsigned FIELD_SYNC    = 0;
  localparam int unsigned FIELD_ADDR    = 1;
  localparam int unsigned FIELD_LEN     = 2;
  localparam int unsigned FIELD_PAYLOAD = 3;
  localparam int unsigned FIELD_CHK     = 4;

  // Bytes in a frame besides the payload: SYNC, ADDR, LEN, CHK.
  localparam int unsigned FRAME_OVERHEAD = 4;

  // States in which a frame is partially received and the gap timer runs.
  function automatic logic in_frame(input state_e s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/serial_frame_timer.sv
// Inter-byte gap counter: clears on demand, counts while enabled, flags the terminal cycle.
module serial_frame_timer #(
  parameter int unsigned TIMEOUT_CLKS = 16300
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles; saturate at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TERM)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = enable && (count == TERM);

endmodule

// File: rtl/serial_cmd_parser.sv
// Frames the UART byte stream into SYNC/ADDR/LEN/payload/CHK commands and holds
// each checked command behind a valid/ready handshake.
module serial_cmd_parser
  import serial_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = 16300,
  parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
  parameter int unsigned IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_new,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_addr,
  output logic [LEN_W-1:0] cmd_len,
  input  logic [IDX_W-1:0] pl_idx,
  output logic [7:0]       pl_data,
  output logic             err_chk,
  output logic             err_len,
  output logic             err_timeout,
  output logic             err_overrun
);

  state_e           state;
  logic [7:0]       frame_addr;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       chk;
  logic [IDX_W-1:0] idx;
  logic [7:0]       pl_buf [MAX_LEN];

  logic timer_en;
  logic timer_clr;
  logic timer_expired_c;

  // The gap timer only runs mid-frame; any byte or leaving the frame resets it.
  assign timer_en  = in_frame(state);
  assign timer_clr = rx_new || !timer_en;

  serial_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clr),
    .enable   (timer_en),
    .expired_c(timer_expired_c)
  );

  // Frame parser, checksum, payload capture and command hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      frame_addr  <= '0;
      frame_len   <= '0;
      chk         <= '0;
      idx         <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) pl_buf[i] <= '0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      if (timer_expired_c && !rx_new) begin
        err_timeout <= 1'b1;
        state       <= ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (rx_new && (rx_data == SYNC_BYTE)) state <= ST_ADDR;
          end
          ST_ADDR: begin
            if (rx_new) begin
              frame_addr <= rx_data;
              chk        <= rx_data;
              state      <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_new) begin
              if (rx_data > 8'(MAX_LEN)) begin
                err_len <= 1'b1;
                state   <= ST_HUNT;
              end else begin
                frame_len <= LEN_W'(rx_data);
                chk       <= chk ^ rx_data;
                idx       <= '0;
                state     <= (rx_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_new) begin
              pl_buf[idx] <= rx_data;
              chk         <= chk ^ rx_data;
              idx         <= idx + IDX_W'(1);
              if (LEN_W'(idx) == (frame_len - LEN_W'(1))) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (rx_new) begin
              if (rx_data == chk) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= frame_addr;
                cmd_len   <= frame_len;
                state     <= ST_HOLD;
              end else begin
                err_chk <= 1'b1;
                state   <= ST_HUNT;
              end
            end
          end
          ST_HOLD: begin
            // A byte in the handshake cycle is treated as if already back in HUNT.
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= (rx_new && (rx_data == SYNC_BYTE)) ? ST_ADDR : ST_HUNT;
            end else if (rx_new) begin
              err_overrun <= 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // Payload read port; indices past the held length read as zero.
  always_comb begin
    pl_data = 8'h00;
    if (LEN_W'(pl_idx) < cmd_len) pl_data = pl_buf[pl_idx];
  end

endmodule
